vigenere_stream: RTL and testbench

//  Streaming Vigenere cipher, the parametrised successor of the single-key Caesar stage.

---
 rtl/vigenere_pkg.sv | 46 ++++
 rtl/vig_key_sched.sv | 53 +++++
 rtl/vigenere_stream.sv | 112 +++++++++++
 tb/tb_vigenere_stream.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vigenere_pkg.sv
// Shared types, constants and letter helpers for the streaming Vigenere cipher.
// Helpers are combinational; they are only referenced when VIGENERE_ALPHA_EN is defined.
package vigenere_pkg;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int         ALPHA_N  = 26;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_LA = 8'h61;

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= ASCII_UA) && (c < ASCII_UA + 8'(ALPHA_N));
    endfunction

    function automatic logic is_lower(input logic [7:0] c);
        return (c >= ASCII_LA) && (c < ASCII_LA + 8'(ALPHA_N));
    endfunction

    function automatic logic is_letter(input logic [7:0] c);
        return is_upper(c) || is_lower(c);
    endfunction

    // Rotate a letter by s (0..25) within its own case; decrypt adds 26-s to stay non-negative.
    function automatic logic [7:0] alpha_shift(input logic [7:0] c, input logic [4:0] s,
                                               input logic dec);
        logic [7:0] base;
        logic [7:0] off;
        logic [7:0] r;
        base = is_upper(c) ? ASCII_UA : ASCII_LA;
        off  = c - base;
        r    = dec ? (off + 8'(ALPHA_N) - {3'b000, s}) : (off + {3'b000, s});
        if (r >= 8'(ALPHA_N)) begin
            r = r - 8'(ALPHA_N);
        end
        return base + r;
    endfunction

endpackage

// File: rtl/vig_key_sched.sv
// Key storage and repeating key index; key_sym is the key symbol for the symbol now offered.
// Latency: key_sym is combinational from sop/key_idx; index updates on the accepting edge.
// Backpressure: none of its own; it only moves when the top signals an accepted symbol.
module vig_key_sched
    import vigenere_pkg::*;
#(
    parameter int D_WIDTH     = 8,
    parameter int MAX_KEY_LEN = 16,
    parameter int KL_W        = $clog2(MAX_KEY_LEN + 1)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           load,
    input  logic [MAX_KEY_LEN*D_WIDTH-1:0] key_in,
    input  logic [KL_W-1:0]                key_len,
    input  logic                           step,
    input  logic                           advance,
    input  logic                           sop,
    output logic [D_WIDTH-1:0]             key_sym
);

    logic [MAX_KEY_LEN*D_WIDTH-1:0] key_q;
    logic [KL_W-1:0]                len_q;
    logic [KL_W-1:0]                key_idx;
    logic [KL_W-1:0]                k;
    logic [KL_W-1:0]                k_inc;
    logic [KL_W-1:0]                k_next;

    assign k       = sop ? '0 : key_idx;
    assign k_inc   = k + KL_W'(1);
    assign k_next  = (k_inc == len_q) ? '0 : k_inc;
    assign key_sym = key_q[k*D_WIDTH +: D_WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q   <= '0;
            len_q   <= '0;
            key_idx <= '0;
        end else if (load) begin
            key_q   <= key_in;
            len_q   <= key_len;
            key_idx <= '0;
        end else if (step) begin
            // A skipped symbol carrying sop still restarts the key for the next letter.
            if (advance) begin
                key_idx <= k_next;
            end else if (sop) begin
                key_idx <= '0;
            end
        end
    end

endmodule

// File: rtl/vigenere_stream.sv
// Streaming Vigenere cipher (byte add/subtract; letters-only rotate-26 when VIGENERE_ALPHA_EN).
// Latency: 1 cycle, registered output, one symbol per cycle sustained.
// Backpressure: in_ready drops when the output register is full and out_ready is low, or on key_load.
module vigenere_stream
    import vigenere_pkg::*;
#(
    parameter int D_WIDTH     = 8,
    parameter int MAX_KEY_LEN = 16,
    parameter int KL_W        = $clog2(MAX_KEY_LEN + 1)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           key_load,
    input  logic [MAX_KEY_LEN*D_WIDTH-1:0] key_in,
    input  logic [KL_W-1:0]                key_len,
    input  logic                           mode,
    output logic                           key_valid,
    output logic                           key_err,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_sop,
    input  logic [D_WIDTH-1:0]             in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [D_WIDTH-1:0]             out_data
);

    state_e             state;
    mode_e              mode_q;
    logic               key_ok;
    logic               accept;
    logic               advance;
    logic [D_WIDTH-1:0] key_sym;
    logic [D_WIDTH-1:0] result;

    assign in_ready = (state == ST_RUN) && !key_load && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        key_ok = (key_len != '0) && (int'(key_len) <= MAX_KEY_LEN);
`ifdef VIGENERE_ALPHA_EN
        for (int i = 0; i < MAX_KEY_LEN; i++) begin
            if ((i < int'(key_len)) && !is_letter(key_in[i*D_WIDTH +: 8])) begin
                key_ok = 1'b0;
            end
        end
`endif
    end

    vig_key_sched #(
        .D_WIDTH     (D_WIDTH),
        .MAX_KEY_LEN (MAX_KEY_LEN),
        .KL_W        (KL_W)
    ) u_key_sched (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (key_load && key_ok),
        .key_in  (key_in),
        .key_len (key_len),
        .step    (accept),
        .advance (advance),
        .sop     (in_sop),
        .key_sym (key_sym)
    );

`ifdef VIGENERE_ALPHA_EN
    logic [4:0] shift;

    // Key letters map A/a..Z/z to shifts 0..25 through their low five bits.
    always_comb begin
        shift   = key_sym[4:0] - 5'd1;
        result  = is_letter(in_data) ? alpha_shift(in_data, shift, mode_q == MODE_DEC) : in_data;
        advance = accept && is_letter(in_data);
    end
`else
    always_comb begin
        result  = (mode_q == MODE_DEC) ? (in_data - key_sym) : (in_data + key_sym);
        advance = accept;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_ENC;
            key_valid <= 1'b0;
            key_err   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (key_load) begin
                if (key_ok) begin
                    state     <= ST_RUN;
                    mode_q    <= mode ? MODE_DEC : MODE_ENC;
                    key_valid <= 1'b1;
                    key_err   <= 1'b0;
                end else begin
                    state     <= ST_IDLE;
                    key_valid <= 1'b0;
                    key_err   <= 1'b1;
                end
            end
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= result;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vigenere_stream.sv
// Directed bench for vigenere_stream; letter-mode vectors are used when VIGENERE_ALPHA_EN is defined.
module tb_vigenere_stream;

    localparam int D_WIDTH     = 8;
    localparam int MAX_KEY_LEN = 16;
    localparam int KL_W        = $clog2(MAX_KEY_LEN + 1);
    localparam int KW          = MAX_KEY_LEN * D_WIDTH;

    logic               clk;
    logic               reset_n;
    logic               key_load;
    logic [KW-1:0]      key_in;
    logic [KL_W-1:0]    key_len;
    logic               mode;
    logic               key_valid;
    logic               key_err;
    logic               in_valid;
    logic               in_ready;
    logic               in_sop;
    logic [D_WIDTH-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [D_WIDTH-1:0] out_data;

    int checks   = 0;
    int failures = 0;

    vigenere_stream #(
        .D_WIDTH     (D_WIDTH),
        .MAX_KEY_LEN (MAX_KEY_LEN)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key_load  (key_load),
        .key_in    (key_in),
        .key_len   (key_len),
        .mode      (mode),
        .key_valid (key_valid),
        .key_err   (key_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sop    (in_sop),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [KW-1:0] mk3(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
        logic [KW-1:0] v;
        v        = '0;
        v[7:0]   = a;
        v[15:8]  = b;
        v[23:16] = c;
        return v;
    endfunction

    // Key load is offered together with a valid input, which must not be accepted.
    task automatic load_key(input logic [KW-1:0] k, input logic [KL_W-1:0] len, input logic md);
        @(negedge clk);
        key_in   = k;
        key_len  = len;
        mode     = md;
        key_load = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        #1 chk("ld_rdy", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        key_load = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic [7:0] d, input logic sop,
                        input logic [7:0] exp);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = sop;
        #1 chk({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        chk({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
        chk(tag, {24'b0, out_data}, {24'b0, exp});
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] held;
        logic       stalled;
        int         tx;
        int         rx;
        logic [7:0] sop_pat;
        logic [7:0] exp3 [7];

        reset_n   = 1'b0;
        key_load  = 1'b0;
        key_in    = '0;
        key_len   = '0;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_kv",   {31'b0, key_valid}, 32'd0);
        chk("rst_ke",   {31'b0, key_err},   32'd0);
        chk("rst_ov",   {31'b0, out_valid}, 32'd0);
        chk("rst_od",   {24'b0, out_data},  32'd0);
        chk("rst_rdy",  {31'b0, in_ready},  32'd0);

`ifdef VIGENERE_ALPHA_EN
        load_key(mk3("K", "E", "Y"), 5'd3, 1'b0);
        chk("a_kv", {31'b0, key_valid}, 32'd1);
        xfer("a_h", "H", 1'b1, "R");
        xfer("a_e", "E", 1'b0, "I");
        xfer("a_l", "L", 1'b0, "J");
        xfer("a_l2", "L", 1'b0, "V");
        xfer("a_o", "O", 1'b0, "S");
        xfer("b_h", "H", 1'b1, "R");
        xfer("b_e", "E", 1'b0, "I");
        xfer("b_sp", " ", 1'b0, " ");
        xfer("b_l", "L", 1'b0, "J");
        xfer("b_l2", "L", 1'b0, "V");
        xfer("b_o", "O", 1'b0, "S");
        xfer("c_lc", "h", 1'b1, "r");
        load_key(mk3("K", "E", "Y"), 5'd3, 1'b1);
        xfer("d_r", "R", 1'b1, "H");
        xfer("d_i", "I", 1'b0, "E");
        xfer("d_j", "J", 1'b0, "L");
        xfer("d_v", "V", 1'b0, "L");
        xfer("d_s", "S", 1'b0, "O");
        load_key(mk3("K", "3", "Y"), 5'd3, 1'b0);
        chk("a_bad_ke", {31'b0, key_err},   32'd1);
        chk("a_bad_kv", {31'b0, key_valid}, 32'd0);
`else
        load_key(mk3(8'h03, 8'h00, 8'h00), 5'd1, 1'b0);
        chk("t1_kv", {31'b0, key_valid}, 32'd1);
        chk("t1_ke", {31'b0, key_err},   32'd0);
        xfer("t1_enc", 8'h05, 1'b1, 8'h08);
        load_key(mk3(8'h03, 8'h00, 8'h00), 5'd1, 1'b1);
        xfer("t1_dec", 8'h05, 1'b1, 8'h02);

        load_key(mk3(8'h02, 8'h00, 8'h00), 5'd1, 1'b0);
        xfer("t2_enc", 8'hFF, 1'b1, 8'h01);
        load_key(mk3(8'h02, 8'h00, 8'h00), 5'd1, 1'b1);
        xfer("t2_dec", 8'h01, 1'b1, 8'hFF);

        load_key(mk3(8'h01, 8'h02, 8'h03), 5'd3, 1'b0);
        exp3 = '{8'h11, 8'h12, 8'h13, 8'h11, 8'h12, 8'h13, 8'h11};
        for (int i = 0; i < 7; i++) begin
            xfer($sformatf("t3_%0d", i), 8'h10, (i == 0), exp3[i]);
        end
        sop_pat = 8'b0001_0001;
        exp3 = '{8'h11, 8'h12, 8'h13, 8'h11, 8'h11, 8'h12, 8'h13};
        for (int i = 0; i < 7; i++) begin
            xfer($sformatf("t3s_%0d", i), 8'h10, sop_pat[i], exp3[i]);
        end

        load_key(mk3(8'h01, 8'h00, 8'h00), 5'd0, 1'b0);
        chk("t4_z_ke",  {31'b0, key_err},   32'd1);
        chk("t4_z_kv",  {31'b0, key_valid}, 32'd0);
        chk("t4_z_rdy", {31'b0, in_ready},  32'd0);
        load_key(mk3(8'h01, 8'h00, 8'h00), 5'd17, 1'b0);
        chk("t4_o_ke",  {31'b0, key_err},   32'd1);
        chk("t4_o_kv",  {31'b0, key_valid}, 32'd0);
        load_key(mk3(8'h01, 8'h00, 8'h00), 5'd16, 1'b0);
        chk("t4_ok_ke", {31'b0, key_err},   32'd0);
        chk("t4_ok_kv", {31'b0, key_valid}, 32'd1);

        // Back-to-back input with out_ready low for cycles 2..4.
        load_key(mk3(8'h01, 8'h02, 8'h03), 5'd3, 1'b0);
        exp_q   = '{8'h21, 8'h23, 8'h25, 8'h24, 8'h26, 8'h28};
        tx      = 0;
        rx      = 0;
        stalled = 1'b0;
        held    = '0;
        for (int c = 0; c < 40 && rx < 6; c++) begin
            @(negedge clk);
            out_ready = !(c >= 2 && c <= 4);
            in_valid  = (tx < 6);
            in_data   = 8'h20 + 8'(tx);
            in_sop    = (tx == 0);
            #1;
            if (stalled) chk("t5_hold", {24'b0, out_data}, {24'b0, held});
            if (out_valid && out_ready) begin
                chk($sformatf("t5_%0d", rx), {24'b0, out_data}, {24'b0, exp_q[rx]});
                rx++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (in_valid && in_ready) tx++;
        end
        chk("t5_cnt", rx, 32'd6);
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        out_ready = 1'b1;

        // Key reload while output pending leaves the pending symbol untouched.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h40;
        in_sop    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        load_key(mk3(8'h05, 8'h00, 8'h00), 5'd1, 1'b0);
        chk("kl_pend_v", {31'b0, out_valid}, 32'd1);
        chk("kl_pend_d", {24'b0, out_data},  32'h41);
        out_ready = 1'b1;
        @(negedge clk);
        xfer("kl_new", 8'h40, 1'b0, 8'h45);
`endif

        // Asynchronous reset in the middle of a held output.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h33;
        in_sop    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        chk("ar_pre_v", {31'b0, out_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_ov",  {31'b0, out_valid}, 32'd0);
        chk("ar_od",  {24'b0, out_data},  32'd0);
        chk("ar_kv",  {31'b0, key_valid}, 32'd0);
        chk("ar_ke",  {31'b0, key_err},   32'd0);
        chk("ar_rdy", {31'b0, in_ready},  32'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
